// File: rtl/modexp_pkg.sv
// Shared types for the modular-exponentiation controller.
// MODEXP_CONVERT_OUT_EN adds the final Montgomery-to-normal conversion states.
package modexp_pkg;

  localparam int WIDTH_DEF = 2048;

  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(WIDTH_DEF);

  typedef enum logic [3:0] {
    IDLE,
    SCAN,
    SQR_REQ,
    SQR_WAIT,
    MUL_REQ,
    MUL_WAIT,
`ifdef MODEXP_CONVERT_OUT_EN
    CONV_REQ,
    CONV_WAIT,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/modexp_bit_scan.sv
// Sequential MSB finder: tests one bit per cycle from WIDTH-1 downwards.
// found/none are combinational on the current index so the caller can act in the same cycle.
module modexp_bit_scan
  import modexp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int IW = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic             none,
  output logic [IW-1:0]    index
);

  logic active;

  assign found = active & vec[index];
  assign none  = active & ~vec[index] & (index == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      index  <= '0;
    end else if (start) begin
      active <= 1'b1;
      index  <= IW'(WIDTH - 1);
    end else if (active) begin
      if (found || none) active <= 1'b0;
      else               index  <= index - 1'b1;
    end
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external Montgomery multiplier.
// MODEXP_CONVERT_OUT_EN: when defined, result is converted out of Montgomery form via mm(acc, 1).
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base_m,
  input  logic [WIDTH-1:0] one_m,
  input  logic [WIDTH-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result
);

  localparam int IW = idx_w(WIDTH);
`ifdef MODEXP_CONVERT_OUT_EN
  localparam state_t FIN = CONV_REQ;
`else
  localparam state_t FIN = DONE;
`endif

  state_t           state, state_d;
  logic [WIDTH-1:0] base_r, one_r, exp_r, acc, acc_d;
  logic [IW-1:0]    bit_idx, scan_idx;
  logic             scan_found, scan_none, accept, last, in_wait;

  assign accept = (state == IDLE) && start;
  assign last   = (bit_idx == '0);

  modexp_bit_scan #(.WIDTH(WIDTH)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .vec   (exp_r),
    .found (scan_found),
    .none  (scan_none),
    .index (scan_idx)
  );

  always_comb begin
    in_wait = (state == SQR_WAIT) || (state == MUL_WAIT);
`ifdef MODEXP_CONVERT_OUT_EN
    if (state == CONV_WAIT) in_wait = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (start) state_d = SCAN;
      SCAN:     if (scan_found)    state_d = (scan_idx == '0) ? FIN : SQR_REQ;
                else if (scan_none) state_d = FIN;
      SQR_REQ:  state_d = SQR_WAIT;
      SQR_WAIT: if (mm_done) state_d = exp_r[bit_idx] ? MUL_REQ : (last ? FIN : SQR_REQ);
      MUL_REQ:  state_d = MUL_WAIT;
      MUL_WAIT: if (mm_done) state_d = last ? FIN : SQR_REQ;
`ifdef MODEXP_CONVERT_OUT_EN
      CONV_REQ:  state_d = CONV_WAIT;
      CONV_WAIT: if (mm_done) state_d = DONE;
`endif
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE) && (state != DONE);
    done     = (state == DONE);
    mm_start = 1'b0;
    mm_a     = '0;
    mm_b     = '0;
    case (state)
      SQR_REQ, SQR_WAIT: begin
        mm_start = (state == SQR_REQ);
        mm_a     = acc;
        mm_b     = acc;
      end
      MUL_REQ, MUL_WAIT: begin
        mm_start = (state == MUL_REQ);
        mm_a     = acc;
        mm_b     = base_r;
      end
`ifdef MODEXP_CONVERT_OUT_EN
      CONV_REQ, CONV_WAIT: begin
        mm_start = (state == CONV_REQ);
        mm_a     = acc;
        mm_b     = WIDTH'(1);
      end
`endif
      default: ;
    endcase
  end

  // Next accumulator value; result latches it on entry to DONE so it is valid alongside done.
  always_comb begin
    acc_d = acc;
    if (state == SCAN && scan_found)     acc_d = base_r;
    else if (state == SCAN && scan_none) acc_d = one_r;
    else if (in_wait && mm_done)         acc_d = mm_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r  <= '0;
      one_r   <= '0;
      exp_r   <= '0;
      acc     <= '0;
      result  <= '0;
      bit_idx <= '0;
    end else begin
      if (accept) begin
        base_r <= base_m;
        one_r  <= one_m;
        exp_r  <= exp;
      end
      acc <= acc_d;
      if (state_d == DONE) result <= acc_d;
      if (state == SCAN && scan_found) bit_idx <= scan_idx - 1'b1;
      else if (state_d == SQR_REQ)     bit_idx <= bit_idx - 1'b1;
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl at WIDTH=8 with a behavioural Montgomery multiplier (n=13, R=256, 3-cycle latency).
module tb_modexp_ctrl;

  localparam int W   = 8;
  localparam int N   = 13;
  localparam int R   = 256;
  localparam int LAT = 3;
`ifdef MODEXP_CONVERT_OUT_EN
  localparam int CONV = 1;
`else
  localparam int CONV = 0;
`endif

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] base_m = '0, one_m = '0, e_in = '0;
  logic         busy, done, mm_start;
  logic [W-1:0] result, mm_a, mm_b;
  logic         mm_done = 1'b0;
  logic [W-1:0] mm_result = '0;

  int nvec = 0, nbad = 0, nreq = 0, pend = 0;
  logic [W-1:0] pend_val = '0;

  always #5 clk = ~clk;

  modexp_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_m    (base_m),
    .one_m     (one_m),
    .exp       (e_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_done   (mm_done),
    .mm_result (mm_result)
  );

  function automatic int r_inv();
    for (int r = 1; r < N; r++) if ((R * r) % N == 1) return r;
    return 0;
  endfunction

  function automatic int mont(input int a, input int b);
    return (((a * b) % N) * r_inv()) % N;
  endfunction

  function automatic int powmod(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % N;
    return r;
  endfunction

  // Expected final value: b^e mod n, left in Montgomery form unless conversion is built in.
  function automatic int ref_result(input int b, input int e);
    int p = powmod(b, e);
    return CONV ? p : (p * R) % N;
  endfunction

  function automatic int ref_reqs(input int e);
    int msb = 0;
    if (e == 0) return CONV;
    for (int i = 0; i < W; i++) if ((e >> i) & 1) msb = i;
    return msb + $countones(e) - 1 + CONV;
  endfunction

  // Multiplier model: count every request, answer LAT cycles later whatever the DUT state.
  initial forever begin
    @(posedge clk); #1;
    mm_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mm_done   = 1'b1;
        mm_result = pend_val;
      end
    end
    if (mm_start) begin
      nreq++;
      pend     = LAT;
      pend_val = W'(mont(int'(mm_a), int'(mm_b)));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // One exponentiation; poke>=0 pulses a conflicting start that many cycles into the run.
  task automatic run(input string nm, input int b, input int e, input int xres, input int xreq,
                     input int poke);
    int n0, cyc;
    @(negedge clk);
    base_m = W'((b * R) % N);
    one_m  = W'(R % N);
    e_in   = W'(e);
    start  = 1'b1;
    n0     = nreq;
    @(negedge clk);
    start  = 1'b0;
    chk({nm, ".busy"}, 32'(busy), 1);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke) begin
        start = 1'b1; e_in = W'(1); base_m = W'(1); one_m = W'(1);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, ".done"}, 32'(done), 1);
    chk({nm, ".result"}, 32'(result), xres);
    chk({nm, ".reqs"}, nreq - n0, xreq);
    @(negedge clk);
    chk({nm, ".idle"}, {30'd0, busy, done}, 0);
    chk({nm, ".held"}, 32'(result), xres);
  endtask

  typedef struct {
    int b;
    int e;
    int res;
    int reqs;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int saw, b, e;
`ifdef MODEXP_CONVERT_OUT_EN
    tbl[0] = '{2, 11, 7, 6};
    tbl[1] = '{2, 0, 1, 1};
    tbl[2] = '{2, 1, 2, 1};
    tbl[3] = '{2, 128, 9, 8};
`else
    tbl[0] = '{2, 11, 11, 5};
    tbl[1] = '{2, 0, 9, 0};
    tbl[2] = '{2, 1, 5, 0};
    tbl[3] = '{2, 128, 3, 7};
`endif

    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.mm_start", 32'(mm_start), 0);
    chk("rst.mm_ab", {16'd0, mm_a, mm_b}, 0);
    chk("rst.result", 32'(result), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run($sformatf("tbl%0d", i), tbl[i].b, tbl[i].e, tbl[i].res, tbl[i].reqs, -1);

    run("ignored_start", 2, 11, tbl[0].res, tbl[0].reqs, 5);

    // Abort during the first square's wait; the late mm_done must not revive the block.
    @(negedge clk);
    base_m = W'(5); one_m = W'(9); e_in = W'(11); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw = 0;
    while (!mm_start && saw < 100) begin @(negedge clk); saw++; end
    chk("abort.sqr_req", 32'(mm_start), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy_async", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy || mm_start) saw++;
    end
    chk("abort.quiet", saw, 0);
    chk("abort.result", 32'(result), 0);
    run("after_abort", 2, 11, tbl[0].res, tbl[0].reqs, -1);

    for (int i = 0; i < 20; i++) begin
      b = $urandom_range(0, N - 1);
      e = $urandom_range(0, (1 << W) - 1);
      run($sformatf("rnd%0d_b%0d_e%0d", i, b, e), b, e, ref_result(b, e), ref_reqs(e), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
